bank_sram_write_ctrl: RTL and testbench

BANK_SRAM_WRITE_CTRL -- requirements
Module: bank_sram_write_ctrl

---
 rtl/bank_sram_write_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_bank_sram_write_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_sram_write_ctrl.sv
// Two-requester write front-end for a banked SRAM, with a configurable XOR butterfly bank permutation.
// Optional transfer/conflict counters are enabled by defining BANK_SRAM_WRITE_CTRL_PERF_EN.
module bank_sram_write_ctrl #(
    parameter int BW     = 8,
    parameter int NDATA  = 32,
    parameter int NBANK  = 16,
    parameter int XOR_BW = 4
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_cfg_rdy,
    output logic                                    o_cfg_ack,
    input  logic [$clog2(NBANK)-1:0]                i_cfg_xor_mask,
    input  logic [$clog2(XOR_BW)*$clog2(NBANK)-1:0] i_cfg_xor_scheme,
    input  logic [1:0]                              i_wr_rdy,
    output logic [1:0]                              o_wr_ack,
    input  logic [2*$clog2(NDATA)-1:0]              i_wr_hiaddr,
    input  logic [2*NBANK*BW-1:0]                   i_wr_data,
    input  logic [2*NBANK-1:0]                      i_wr_be,
    output logic [NBANK-1:0]                        o_sram_we,
    output logic [$clog2(NDATA)-1:0]                o_sram_addr,
    output logic [NBANK*BW-1:0]                     o_sram_wdata,
    output logic                                    o_busy
`ifdef BANK_SRAM_WRITE_CTRL_PERF_EN
    ,
    output logic [31:0]                             o_perf_wr,
    output logic [31:0]                             o_perf_conflict
`endif
);

    localparam int AW  = $clog2(NDATA);
    localparam int BSW = $clog2(NBANK);
    localparam int XSW = $clog2(XOR_BW);
    localparam int DW  = NBANK * BW;

    typedef enum logic [1:0] {
        CFG_WAIT = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    function automatic logic [BSW-1:0] butterfly(input logic [AW-1:0] addr,
                                                 input logic [BSW-1:0] mask,
                                                 input logic [XSW*BSW-1:0] scheme);
        logic [BSW-1:0] m;
        logic [AW-1:0]  sh;
        m = {BSW{1'b0}};
        for (int i = 0; i < BSW; i++) begin
            sh   = addr >> scheme[i*XSW +: XSW];
            m[i] = sh[0] & mask[i];
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] permute_data(input logic [DW-1:0] d, input logic [BSW-1:0] m);
        logic [DW-1:0] p;
        p = {DW{1'b0}};
        for (int j = 0; j < NBANK; j++) begin
            p[j*BW +: BW] = d[(j ^ int'(m))*BW +: BW];
        end
        return p;
    endfunction

    function automatic logic [NBANK-1:0] permute_be(input logic [NBANK-1:0] b, input logic [BSW-1:0] m);
        logic [NBANK-1:0] p;
        p = {NBANK{1'b0}};
        for (int j = 0; j < NBANK; j++) begin
            p[j] = b[j ^ int'(m)];
        end
        return p;
    endfunction

    state_t             state_r, state_s;
    logic               cfg_ack_s;
    logic [1:0]         ack_s;
    logic               xfer_s;
    logic               sel_s;
    logic               contested_s;
    logic [BSW-1:0]     cfg_mask_r;
    logic [XSW*BSW-1:0] cfg_scheme_r;
    logic               prio_r;
    logic               s1_valid_r;
    logic [AW-1:0]      s1_addr_r;
    logic [DW-1:0]      s1_data_r;
    logic [NBANK-1:0]   s1_be_r;
    logic               s2_valid_r;
    logic [BSW-1:0]     bfly_s;

    // Next-state, grant and configuration-ack decode.
    always_comb begin
        state_s   = state_r;
        cfg_ack_s = 1'b0;
        ack_s     = 2'b00;
        case (state_r)
            CFG_WAIT: begin
                if (i_cfg_rdy) begin
                    cfg_ack_s = 1'b1;
                    state_s   = RUN;
                end else begin
                    state_s   = CFG_WAIT;
                end
            end
            RUN: begin
                if (i_cfg_rdy) begin
                    state_s = DRAIN;
                end else begin
                    case (i_wr_rdy)
                        2'b01:   ack_s = 2'b01;
                        2'b10:   ack_s = 2'b10;
                        2'b11:   ack_s = prio_r ? 2'b10 : 2'b01;
                        default: ack_s = 2'b00;
                    endcase
                end
            end
            DRAIN: begin
                // Reconfigure only once nothing granted under the old mask is still in flight.
                if (!s1_valid_r && !s2_valid_r) begin
                    cfg_ack_s = 1'b1;
                    state_s   = RUN;
                end else begin
                    state_s   = DRAIN;
                end
            end
            default: state_s = CFG_WAIT;
        endcase
    end

    assign xfer_s      = |ack_s;
    assign sel_s       = ack_s[1];
    assign contested_s = (state_r == RUN) && !i_cfg_rdy && (i_wr_rdy == 2'b11);
    assign o_wr_ack    = ack_s;
    assign o_cfg_ack   = cfg_ack_s;
    assign bfly_s      = butterfly(s1_addr_r, cfg_mask_r, cfg_scheme_r);

    // FSM state, configuration registers and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r      <= CFG_WAIT;
            cfg_mask_r   <= {BSW{1'b0}};
            cfg_scheme_r <= {(XSW*BSW){1'b0}};
            prio_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            if (cfg_ack_s) begin
                cfg_mask_r   <= i_cfg_xor_mask;
                cfg_scheme_r <= i_cfg_xor_scheme;
            end
            if (contested_s) begin
                prio_r <= ~prio_r;
            end
        end
    end

    // Stage 1: capture the granted requester's write.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= {AW{1'b0}};
            s1_data_r  <= {DW{1'b0}};
            s1_be_r    <= {NBANK{1'b0}};
        end else begin
            s1_valid_r <= xfer_s;
            if (xfer_s) begin
                s1_addr_r <= sel_s ? i_wr_hiaddr[AW +: AW] : i_wr_hiaddr[0 +: AW];
                s1_data_r <= sel_s ? i_wr_data[DW +: DW]   : i_wr_data[0 +: DW];
                s1_be_r   <= sel_s ? i_wr_be[NBANK +: NBANK] : i_wr_be[0 +: NBANK];
            end
        end
    end

    // Stage 2: permuted SRAM drive; address and data hold while the pipe is empty.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s2_valid_r   <= 1'b0;
            o_busy       <= 1'b0;
            o_sram_we    <= {NBANK{1'b0}};
            o_sram_addr  <= {AW{1'b0}};
            o_sram_wdata <= {DW{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            o_busy     <= xfer_s | s1_valid_r;
            if (s1_valid_r) begin
                o_sram_we    <= permute_be(s1_be_r, bfly_s);
                o_sram_addr  <= s1_addr_r;
                o_sram_wdata <= permute_data(s1_data_r, bfly_s);
            end else begin
                o_sram_we    <= {NBANK{1'b0}};
            end
        end
    end

`ifdef BANK_SRAM_WRITE_CTRL_PERF_EN
    logic conflict_s;
    assign conflict_s = (state_r == RUN) && (i_wr_rdy == 2'b11);

    // Saturating transfer and conflict counters.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_perf_wr       <= 32'd0;
            o_perf_conflict <= 32'd0;
        end else begin
            if (xfer_s && (o_perf_wr != 32'hFFFF_FFFF)) begin
                o_perf_wr <= o_perf_wr + 32'd1;
            end
            if (conflict_s && (o_perf_conflict != 32'hFFFF_FFFF)) begin
                o_perf_conflict <= o_perf_conflict + 32'd1;
            end
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_bank_sram_write_ctrl.sv
// Self-checking bench for bank_sram_write_ctrl: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_bank_sram_write_ctrl;

    localparam int AW   = 5;
    localparam int NB   = 16;
    localparam int DW   = 128;
    localparam int MAXC = 4096;

    logic         clk;
    logic         rst_n;
    logic         cfg_rdy;
    logic         cfg_ack;
    logic [3:0]   cfg_mask;
    logic [7:0]   cfg_scheme;
    logic [1:0]   wr_rdy;
    logic [1:0]   wr_ack;
    logic [9:0]   wr_hiaddr;
    logic [255:0] wr_data;
    logic [31:0]  wr_be;
    logic [15:0]  sram_we;
    logic [4:0]   sram_addr;
    logic [127:0] sram_wdata;
    logic         busy;
`ifdef BANK_SRAM_WRITE_CTRL_PERF_EN
    logic [31:0]  perf_wr;
    logic [31:0]  perf_conflict;
`endif

    bank_sram_write_ctrl dut (
        .i_clk            (clk),
        .i_rst            (rst_n),
        .i_cfg_rdy        (cfg_rdy),
        .o_cfg_ack        (cfg_ack),
        .i_cfg_xor_mask   (cfg_mask),
        .i_cfg_xor_scheme (cfg_scheme),
        .i_wr_rdy         (wr_rdy),
        .o_wr_ack         (wr_ack),
        .i_wr_hiaddr      (wr_hiaddr),
        .i_wr_data        (wr_data),
        .i_wr_be          (wr_be),
        .o_sram_we        (sram_we),
        .o_sram_addr      (sram_addr),
        .o_sram_wdata     (sram_wdata),
        .o_busy           (busy)
`ifdef BANK_SRAM_WRITE_CTRL_PERF_EN
        ,
        .o_perf_wr        (perf_wr),
        .o_perf_conflict  (perf_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fails;
    int cyc;

    // Reference model state: 0 waiting for config, 1 running, 2 draining.
    int           m_mode;
    bit           m_ptr;
    logic [3:0]   m_mask;
    logic [7:0]   m_scheme;
    logic [4:0]   last_addr;
    logic [127:0] last_data;
    logic [31:0]  m_perf_wr;
    logic [31:0]  m_perf_cf;
    bit           x_valid [MAXC];
    logic [15:0]  x_we    [MAXC];
    logic [4:0]   x_addr  [MAXC];
    logic [127:0] x_data  [MAXC];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_bfly(input logic [4:0] addr, input logic [3:0] mask,
                                            input logic [7:0] scheme);
        logic [3:0] m;
        logic [7:0] sh;
        logic [4:0] a;
        m = 4'd0;
        for (int i = 0; i < 4; i++) begin
            sh = scheme >> (2 * i);
            a  = addr >> sh[1:0];
            if (mask[i] && a[0]) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_step();
        logic [1:0]  exp_ack;
        logic        exp_cfg_ack;
        logic        pend1;
        logic        pend2;
        logic [15:0] exp_we;
        logic [3:0]  m;
        logic [4:0]  a;
        logic [127:0] d;
        logic [15:0] b;
        int          r;
        int          src;
        if (!rst_n) begin
            m_mode = 0; m_ptr = 1'b0; m_mask = 4'd0; m_scheme = 8'd0;
            last_addr = 5'd0; last_data = 128'd0; m_perf_wr = 32'd0; m_perf_cf = 32'd0;
            if (cyc >= 1) x_valid[cyc-1] = 1'b0;
            if (cyc >= 2) x_valid[cyc-2] = 1'b0;
            x_valid[cyc] = 1'b0;
            check_val("rst_we", sram_we, 128'd0);
            check_val("rst_addr", sram_addr, 128'd0);
            check_val("rst_wdata", sram_wdata, 128'd0);
            check_val("rst_busy", busy, 128'd0);
            check_val("rst_ack", wr_ack, 128'd0);
            check_val("rst_cfg_ack", cfg_ack, 128'd0);
`ifdef BANK_SRAM_WRITE_CTRL_PERF_EN
            check_val("rst_perf_wr", perf_wr, 128'd0);
            check_val("rst_perf_cf", perf_conflict, 128'd0);
`endif
            cyc++;
            return;
        end
        pend1 = (cyc >= 1) && x_valid[cyc-1];
        pend2 = (cyc >= 2) && x_valid[cyc-2];
        exp_we = 16'd0;
        if (pend2) begin
            last_addr = x_addr[cyc-2];
            last_data = x_data[cyc-2];
            exp_we    = x_we[cyc-2];
        end
        exp_ack = 2'b00;
        if (m_mode == 1 && !cfg_rdy) begin
            if (wr_rdy == 2'b11) exp_ack = m_ptr ? 2'b10 : 2'b01;
            else                 exp_ack = wr_rdy;
        end
        exp_cfg_ack = (m_mode == 0 && cfg_rdy) || (m_mode == 2 && !pend1 && !pend2);
        check_val("wr_ack", wr_ack, exp_ack);
        check_val("cfg_ack", cfg_ack, exp_cfg_ack);
        check_val("sram_we", sram_we, exp_we);
        check_val("sram_addr", sram_addr, last_addr);
        check_val("sram_wdata", sram_wdata, last_data);
        check_val("busy", busy, pend1 || pend2);
`ifdef BANK_SRAM_WRITE_CTRL_PERF_EN
        check_val("perf_wr", perf_wr, m_perf_wr);
        check_val("perf_cf", perf_conflict, m_perf_cf);
`endif
        x_valid[cyc] = 1'b0;
        if (exp_ack != 2'b00) begin
            r = exp_ack[1] ? 1 : 0;
            a = wr_hiaddr[r*5 +: 5];
            d = wr_data[r*128 +: 128];
            b = wr_be[r*16 +: 16];
            m = ref_bfly(a, m_mask, m_scheme);
            for (int j = 0; j < NB; j++) begin
                src = j ^ int'(m);
                x_data[cyc][j*8 +: 8] = d[src*8 +: 8];
                x_we[cyc][j]          = b[src];
            end
            x_addr[cyc]  = a;
            x_valid[cyc] = 1'b1;
            if (m_perf_wr != 32'hFFFF_FFFF) m_perf_wr++;
        end
        if (m_mode == 1 && wr_rdy == 2'b11 && m_perf_cf != 32'hFFFF_FFFF) m_perf_cf++;
        if (m_mode == 1 && !cfg_rdy && wr_rdy == 2'b11) m_ptr = !m_ptr;
        case (m_mode)
            0: if (cfg_rdy) begin m_mask = cfg_mask; m_scheme = cfg_scheme; m_mode = 1; end
            1: if (cfg_rdy) m_mode = 2;
            default: if (!pend1 && !pend2) begin m_mask = cfg_mask; m_scheme = cfg_scheme; m_mode = 1; end
        endcase
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq(input int r);
        for (int j = 0; j < NB; j++) wr_data[r*128 + j*8 +: 8] = 8'(j);
    endtask

    task automatic randomize_inputs();
        cfg_rdy    = ($urandom_range(0, 15) == 0);
        cfg_mask   = 4'($urandom);
        cfg_scheme = 8'($urandom);
        wr_rdy     = 2'($urandom);
        wr_hiaddr  = 10'($urandom);
        for (int k = 0; k < 8; k++) wr_data[k*32 +: 32] = $urandom;
        wr_be      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    endtask

    initial begin
        n_checks = 0; n_fails = 0; cyc = 0;
        rst_n = 1'b0; cfg_rdy = 1'b0; cfg_mask = 4'd0; cfg_scheme = 8'd0;
        wr_rdy = 2'b00; wr_hiaddr = 10'd0; wr_data = 256'd0; wr_be = 32'd0;
        @(posedge clk);
        #1;
        repeat (2) tick();
        rst_n = 1'b1;

        // Requests before any configuration receive no grant.
        wr_rdy = 2'b11;
        repeat (3) begin
            #1 check_val("no_cfg_grant", wr_ack, 128'd0);
            tick();
        end
        wr_rdy = 2'b00; cfg_rdy = 1'b1; cfg_mask = 4'b0001; cfg_scheme = 8'h00;
        #1 check_val("first_cfg_ack", cfg_ack, 128'd1);
        tick();
        cfg_rdy = 1'b0;

        // Contested requests alternate starting with requester 0.
        wr_rdy = 2'b11; wr_be = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 8; w++) wr_data[w*32 +: 32] = $urandom;
            #1 check_val("grant_order", wr_ack, (k % 2 == 1) ? 128'd2 : 128'd1);
            tick();
        end
        wr_rdy = 2'b00;
        repeat (2) tick();

        // Single write through mask 0001 swaps adjacent banks.
        wr_rdy = 2'b01; wr_hiaddr[4:0] = 5'd1; load_seq(0); wr_be = 32'hFFFF_FFFF;
        tick();
        wr_rdy = 2'b00;
        tick();
        check_val("perm_bank0", sram_wdata[7:0], 128'd1);
        check_val("perm_bank1", sram_wdata[15:8], 128'd0);
        check_val("perm_we", sram_we, 128'hFFFF);
        check_val("perm_addr", sram_addr, 128'd1);

        // Reconfiguration while two writes are in flight.
        wr_rdy = 2'b10; wr_hiaddr[9:5] = 5'($urandom);
        tick();
        wr_rdy = 2'b01; wr_hiaddr[4:0] = 5'd1; load_seq(0);
        tick();
        wr_rdy = 2'b00; cfg_rdy = 1'b1; cfg_mask = 4'b0010; cfg_scheme = 8'h00;
        #1 check_val("drain_req_grant", wr_ack, 128'd0);
        check_val("drain_req_noack", cfg_ack, 128'd0);
        tick();
        cfg_rdy = 1'b0;
        check_val("drain_old_mask", sram_wdata[7:0], 128'd1);
        #1 check_val("drain_wait_ack", cfg_ack, 128'd0);
        tick();
        #1 check_val("drain_ack", cfg_ack, 128'd1);
        tick();
        wr_rdy = 2'b01; wr_hiaddr[4:0] = 5'd1; load_seq(0);
        tick();
        wr_rdy = 2'b00;
        tick();
        check_val("new_mask", sram_wdata[7:0], 128'd2);

        // Reset the cycle after a grant discards the write.
        wr_rdy = 2'b01;
        #1 check_val("pre_rst_grant", wr_ack, 128'd1);
        tick();
        rst_n = 1'b0; wr_rdy = 2'b00;
        #1 check_val("rst_mid_we", sram_we, 128'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        wr_rdy = 2'b11;
        repeat (3) begin
            #1 check_val("post_rst_grant", wr_ack, 128'd0);
            check_val("post_rst_we", sram_we, 128'd0);
            tick();
        end

        // Ten transfers including three contested cycles.
        wr_rdy = 2'b00; cfg_rdy = 1'b1; cfg_mask = 4'($urandom); cfg_scheme = 8'($urandom);
        tick();
        cfg_rdy = 1'b0; wr_rdy = 2'b11;
        repeat (3) tick();
        wr_rdy = 2'b01;
        repeat (7) tick();
        wr_rdy = 2'b00;
        tick();
`ifdef BANK_SRAM_WRITE_CTRL_PERF_EN
        check_val("perf_wr_10", perf_wr, 128'd10);
        check_val("perf_cf_3", perf_conflict, 128'd3);
`endif

        // Random traffic with occasional reconfiguration and reset.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; cfg_rdy = 1'b0; wr_rdy = 2'b00;
            end else begin
                rst_n = 1'b1;
                randomize_inputs();
            end
            tick();
        end
        rst_n = 1'b1; cfg_rdy = 1'b0; wr_rdy = 2'b00;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
